rdma_hdr_packer: RTL

Parametrised RDMA header packer. On each accepted request it captures source/destination MAC, the operation bit and the counter field, then serialises them onto an AXI-Stream master as network-byte-order beats of DATA_W bits. Generalises the fixed 32-bit packer: configurable bus width and counter width, captured (not live) fields, partial keep on the final beat, and zero-bubble back-to-back packets. Sits between the parser result stage and the egress stream mux.

---
 rtl/rdma_hdr_packer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rdma_hdr_packer.sv
// rdma_hdr_packer
//   Captures an RDMA header request (source MAC, destination MAC, op bit,
//   counter) and streams it out as network-byte-order AXI-Stream beats of
//   DATA_W bits. Back-to-back packets run with no idle cycle between them.
//
//   Parameters
//     DATA_W : output beat width, power of two, 32..256
//     CNT_W  : counter field width, CNT_W % 8 == 7 so the header is byte aligned
//
//   Ports
//     clk, rst          : clock, asynchronous active-high reset
//     valid_slave       : request valid
//     ready_slave       : request accepted when valid_slave & ready_slave
//     src_address       : source MAC, sampled on accept
//     dst_address       : destination MAC, sampled on accept
//     operation         : op bit, sampled on accept
//     counter           : counter field, sampled on accept
//     data_master       : output beat, byte 0 = first header byte on the wire
//     keep_master       : byte enables
//     valid_master      : beat valid
//     last_master       : final header beat
//     ready_master      : downstream ready
//     busy              : packet in flight
//
//   Build option
//     RDMA_HDR_PACKER_SEQ_EN : the counter port is ignored; the counter field
//     comes from an internal sequence register that starts at 0 and advances
//     by one on every accepted request.
//
//   state | meaning
//   IDLE  | no packet in flight, ready for a request
//   HEAD  | presenting header beats on the master stream

module rdma_hdr_packer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_slave,
    output logic                  ready_slave,
    input  logic [47:0]           src_address,
    input  logic [47:0]           dst_address,
    input  logic                  operation,
    input  logic [CNT_W-1:0]      counter,
    output logic [DATA_W-1:0]     data_master,
    output logic [DATA_W/8-1:0]   keep_master,
    output logic                  valid_master,
    output logic                  last_master,
    input  logic                  ready_master,
    output logic                  busy
);

    localparam int HDR_W   = 97 + CNT_W;
    localparam int NBEATS  = (HDR_W + DATA_W - 1) / DATA_W;
    localparam int KW      = DATA_W / 8;
    localparam int TOT_W   = NBEATS * DATA_W;
    localparam int PAD_W   = TOT_W - HDR_W;
    localparam int BW      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int R_BYTES = (HDR_W - (NBEATS - 1) * DATA_W) / 8;
    localparam logic [KW-1:0] KEEP_LAST = {KW{1'b1}} >> (KW - R_BYTES);

    typedef enum logic {IDLE, HEAD} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [47:0]         src_q, src_d;
    logic [47:0]         dst_q, dst_d;
    logic                op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [KW-1:0]       keep_q, keep_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;

    logic                take;
    logic [CNT_W-1:0]    cnt_src;
    logic [TOT_W-1:0]    hpad;
    logic [DATA_W-1:0]   slice;
    logic [DATA_W-1:0]   rev;

`ifdef RDMA_HDR_PACKER_SEQ_EN
    logic [CNT_W-1:0]    seq_q, seq_d;
    logic                unused_counter;

    assign unused_counter = ^counter;
    assign cnt_src        = seq_q;
`else
    assign cnt_src        = counter;
`endif

    // Accepts in IDLE, or in HEAD only on the final-beat handshake so the
    // next packet can start without a bubble.
    assign ready_slave  = (state_q == IDLE) || (last_q && ready_master);

    assign data_master  = data_q;
    assign keep_master  = keep_q;
    assign valid_master = valid_q;
    assign last_master  = last_q;
    assign busy         = (state_q == HEAD);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_slave) begin
                    take    = 1'b1;
                    beat_d  = '0;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (ready_master) begin
                    if (last_q) begin
                        beat_d = '0;
                        if (valid_slave) begin
                            take = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        src_d = src_q;
        dst_d = dst_q;
        op_d  = op_q;
        cnt_d = cnt_q;
`ifdef RDMA_HDR_PACKER_SEQ_EN
        seq_d = seq_q;
`endif
        if (take) begin
            src_d = src_address;
            dst_d = dst_address;
            op_d  = operation;
            cnt_d = cnt_src;
`ifdef RDMA_HDR_PACKER_SEQ_EN
            seq_d = seq_q + 1'b1;
`endif
        end

        // Header left-justified in a whole number of beats; the zero pad
        // lands at the LSB end of the final beat.
        hpad  = TOT_W'({src_d, dst_d, op_d, cnt_d}) << PAD_W;
        slice = hpad[TOT_W - 1 - int'(beat_d) * DATA_W -: DATA_W];

        // First wire byte (slice MSB byte) goes to data byte 0.
        rev = '0;
        for (int j = 0; j < KW; j++) begin
            rev[8*j +: 8] = slice[DATA_W - 1 - 8*j -: 8];
        end

        valid_d = (state_d == HEAD);
        last_d  = valid_d && (beat_d == BW'(NBEATS - 1));
        data_d  = valid_d ? rev : '0;
        if (!valid_d) begin
            keep_d = '0;
        end else if (last_d) begin
            keep_d = KEEP_LAST;
        end else begin
            keep_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef RDMA_HDR_PACKER_SEQ_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
            last_q  <= last_d;
`ifdef RDMA_HDR_PACKER_SEQ_EN
            seq_q   <= seq_d;
`endif
        end
    end

endmodule
